jelly_colormap_bank_ctl: RTL and testbench

- Programmable, double-buffered colormap for an 8-bit index to 24-bit colour pixel stream.
- The block holds two 256x24 banks:
  - the pixel path reads the active bank;
  - a configuration stream writes the shadow bank.
- A controller swaps the banks at the next frame-start beat after a table load finishes, so a frame never mixes two tables.
- It replaces a fixed colormap table where software must reload palettes at run time.

---
 rtl/jelly_colormap_bank_ctl.sv | 139 +++++++++++++
 tb/tb_jelly_colormap_bank_ctl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/jelly_colormap_bank_ctl.sv
// Double-buffered 8-bit index to 24-bit colour lookup. The pixel path reads the
// active bank while configuration writes fill the shadow bank; banks swap on frame start.
module jelly_colormap_bank_ctl #(
    parameter int USER_WIDTH = 0,
    parameter int USER_BITS  = (USER_WIDTH > 0) ? USER_WIDTH : 1,
    parameter bit INIT_BANK  = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cke,

    input  logic [7:0]           s_cfg_addr,
    input  logic [23:0]          s_cfg_color,
    input  logic                 s_cfg_last,
    input  logic                 s_cfg_valid,
    output logic                 s_cfg_ready,

    input  logic                 ctl_force_swap,

    input  logic [USER_BITS-1:0] s_user,
    input  logic                 s_fs,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    output logic                 s_ready,

    output logic [USER_BITS-1:0] m_user,
    output logic [7:0]           m_data,
    output logic [23:0]          m_color,
    output logic                 m_valid,
    input  logic                 m_ready,

    output logic                 active_bank,
    output logic                 swap_pending
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   active_bank_q, active_bank_d;
    logic                   m_valid_q, m_valid_d;
    logic [7:0]             m_data_q, m_data_d;
    logic [USER_BITS-1:0]   m_user_q, m_user_d;
    logic [23:0]            m_color_q;

    // Bank is the MSB of the RAM address: entries 0..255 are bank 0, 256..511 bank 1.
    logic [23:0]            mem_q [0:511];

    logic                   pix_acc;
    logic                   fs_acc;
    logic                   cfg_acc;
    logic                   rd_sel;
    logic [8:0]             rd_addr_d;
    logic [8:0]             wr_addr_d;

    assign s_ready      = !m_valid_q || m_ready;
    assign s_cfg_ready  = (state_q == ST_IDLE);
    assign swap_pending = (state_q == ST_PENDING);
    assign active_bank  = active_bank_q;
    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign m_user       = m_user_q;
    assign m_color      = m_color_q;

    always_comb begin
        pix_acc       = cke && s_ready && s_valid;
        fs_acc        = pix_acc && s_fs;
        cfg_acc       = cke && s_cfg_valid && s_cfg_ready;
        state_d       = state_q;
        active_bank_d = active_bank_q;

        // A frame-start beat that ends PENDING already reads the new table.
        rd_sel    = active_bank_q ^ ((state_q == ST_PENDING) && fs_acc);
        rd_addr_d = {rd_sel, s_data};
        wr_addr_d = {~active_bank_q, s_cfg_addr};

        case (state_q)
            ST_IDLE: begin
                if (cfg_acc && s_cfg_last) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (fs_acc || (cke && ctl_force_swap)) begin
                    state_d       = ST_IDLE;
                    active_bank_d = ~active_bank_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_user_d  = m_user_q;
        if (s_ready) begin
            m_valid_d = s_valid;
            m_data_d  = s_data;
            m_user_d  = s_user;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            active_bank_q <= INIT_BANK;
            m_valid_q     <= 1'b0;
        end else if (cke) begin
            state_q       <= state_d;
            active_bank_q <= active_bank_d;
            m_valid_q     <= m_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cke) begin
            m_data_q <= m_data_d;
            m_user_q <= m_user_d;
        end
    end

    // Writes only occur in IDLE, where the read side never selects the shadow bank.
    always_ff @(posedge clk) begin
        if (cke) begin
            if (cfg_acc) begin
                mem_q[wr_addr_d] <= s_cfg_color;
            end
            if (s_ready) begin
                m_color_q <= mem_q[rd_addr_d];
            end
        end
    end

endmodule

// File: tb/tb_jelly_colormap_bank_ctl.sv
// Directed bench for jelly_colormap_bank_ctl: palette load, frame-start swap,
// forced swap, back-pressure, clock enable and reset during a pending swap.
module tb_jelly_colormap_bank_ctl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cke;
    logic [7:0]  s_cfg_addr;
    logic [23:0] s_cfg_color;
    logic        s_cfg_last;
    logic        s_cfg_valid;
    logic        s_cfg_ready;
    logic        ctl_force_swap;
    logic [3:0]  s_user;
    logic        s_fs;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  m_user;
    logic [7:0]  m_data;
    logic [23:0] m_color;
    logic        m_valid;
    logic        m_ready;
    logic        active_bank;
    logic        swap_pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jelly_colormap_bank_ctl #(
        .USER_WIDTH (4),
        .INIT_BANK  (1'b0)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cke            (cke),
        .s_cfg_addr     (s_cfg_addr),
        .s_cfg_color    (s_cfg_color),
        .s_cfg_last     (s_cfg_last),
        .s_cfg_valid    (s_cfg_valid),
        .s_cfg_ready    (s_cfg_ready),
        .ctl_force_swap (ctl_force_swap),
        .s_user         (s_user),
        .s_fs           (s_fs),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .m_user         (m_user),
        .m_data         (m_data),
        .m_color        (m_color),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .active_bank    (active_bank),
        .swap_pending   (swap_pending)
    );

    // Writes addresses 0..n-1; colour is addr*0x010101 when ramp=1, else fixed.
    task automatic cfg_load(input logic ramp, input logic [23:0] fixed, input int n,
                            input logic last_on);
        for (int i = 0; i < n; i++) begin
            s_cfg_addr  = 8'(i);
            s_cfg_color = ramp ? (24'(i) * 24'h010101) : fixed;
            s_cfg_last  = last_on && (i == n - 1);
            s_cfg_valid = 1'b1;
            @(negedge clk);
        end
        s_cfg_valid = 1'b0;
        s_cfg_last  = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (active_bank !== 1'b0) begin errors++; $display("FAIL reset_active_bank got %h exp 0", active_bank); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %h exp 0", m_valid); end
        checks++; if (s_cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %h exp 1", s_cfg_ready); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL reset_swap_pending got %h exp 0", swap_pending); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_swap;
        cfg_load(1'b1, 24'h0, 256, 1'b1);
        checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL load_pending got %h exp 1", swap_pending); end
        checks++; if (s_cfg_ready !== 1'b0) begin errors++; $display("FAIL load_cfg_ready got %h exp 0", s_cfg_ready); end
        checks++; if (active_bank !== 1'b0) begin errors++; $display("FAIL load_bank_before got %h exp 0", active_bank); end
        s_valid = 1'b1; s_fs = 1'b1; s_data = 8'h80; s_user = 4'h5;
        @(negedge clk);
        s_valid = 1'b0; s_fs = 1'b0;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL swap_m_valid got %h exp 1", m_valid); end
        checks++; if (m_color !== 24'h808080) begin errors++; $display("FAIL swap_m_color got %h exp 808080", m_color); end
        checks++; if (m_data !== 8'h80) begin errors++; $display("FAIL swap_m_data got %h exp 80", m_data); end
        checks++; if (m_user !== 4'h5) begin errors++; $display("FAIL swap_m_user got %h exp 5", m_user); end
        checks++; if (active_bank !== 1'b1) begin errors++; $display("FAIL swap_bank got %h exp 1", active_bank); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL swap_pending_clr got %h exp 0", swap_pending); end
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL swap_m_valid_drop got %h exp 0", m_valid); end
    endtask

    task automatic test_pending_stream;
        cfg_load(1'b0, 24'hFF0000, 256, 1'b1);
        s_valid = 1'b1; s_fs = 1'b0; s_data = 8'h10; s_user = 4'h1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (m_color !== 24'h101010) begin errors++; $display("FAIL stream_color[%0d] got %h exp 101010", i, m_color); end
            checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL stream_pending[%0d] got %h exp 1", i, swap_pending); end
            checks++; if (s_cfg_ready !== 1'b0) begin errors++; $display("FAIL stream_cfg_ready[%0d] got %h exp 0", i, s_cfg_ready); end
        end
        s_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_force_swap;
        ctl_force_swap = 1'b1;
        @(negedge clk);
        ctl_force_swap = 1'b0;
        checks++; if (active_bank !== 1'b0) begin errors++; $display("FAIL force_bank got %h exp 0", active_bank); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL force_pending got %h exp 0", swap_pending); end
        checks++; if (s_cfg_ready !== 1'b1) begin errors++; $display("FAIL force_cfg_ready got %h exp 1", s_cfg_ready); end
        s_valid = 1'b1; s_data = 8'h10;
        @(negedge clk);
        s_valid = 1'b0;
        checks++; if (m_color !== 24'hFF0000) begin errors++; $display("FAIL force_color got %h exp ff0000", m_color); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 8'h22; s_user = 4'h3;
        @(negedge clk);
        s_data = 8'h33; s_user = 4'h7;
        for (int i = 0; i < 5; i++) begin
            checks++; if (m_data !== 8'h22) begin errors++; $display("FAIL stall_data[%0d] got %h exp 22", i, m_data); end
            checks++; if (m_user !== 4'h3) begin errors++; $display("FAIL stall_user[%0d] got %h exp 3", i, m_user); end
            checks++; if (m_color !== 24'hFF0000) begin errors++; $display("FAIL stall_color[%0d] got %h exp ff0000", i, m_color); end
            checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_s_ready[%0d] got %h exp 0", i, s_ready); end
            checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stall_m_valid[%0d] got %h exp 1", i, m_valid); end
            @(negedge clk);
        end
        m_ready = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        checks++; if (m_data !== 8'h33) begin errors++; $display("FAIL resume_data got %h exp 33", m_data); end
        checks++; if (m_user !== 4'h7) begin errors++; $display("FAIL resume_user got %h exp 7", m_user); end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL resume_valid got %h exp 1", m_valid); end
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL resume_drain got %h exp 0", m_valid); end
    endtask

    task automatic test_cke;
        cke = 1'b0;
        s_valid = 1'b1; s_data = 8'h44; s_user = 4'h9;
        repeat (2) @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL cke_freeze got %h exp 0", m_valid); end
        cke = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL cke_resume_valid got %h exp 1", m_valid); end
        checks++; if (m_data !== 8'h44) begin errors++; $display("FAIL cke_resume_data got %h exp 44", m_data); end
        @(negedge clk);
    endtask

    task automatic test_last_with_fs;
        // Bank 0 active (all ff0000); fill bank 1 with 00abcd, no last yet.
        cfg_load(1'b0, 24'h00ABCD, 255, 1'b0);
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL nolast_pending got %h exp 0", swap_pending); end
        s_cfg_addr = 8'hFF; s_cfg_color = 24'h00ABCD; s_cfg_last = 1'b1; s_cfg_valid = 1'b1;
        s_valid = 1'b1; s_fs = 1'b1; s_data = 8'h20;
        @(negedge clk);
        s_cfg_valid = 1'b0; s_cfg_last = 1'b0; s_valid = 1'b0;
        checks++; if (active_bank !== 1'b0) begin errors++; $display("FAIL lastfs_bank got %h exp 0", active_bank); end
        checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL lastfs_pending got %h exp 1", swap_pending); end
        checks++; if (m_color !== 24'hFF0000) begin errors++; $display("FAIL lastfs_color got %h exp ff0000", m_color); end
        @(negedge clk);
        checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL fs_novalid_pending got %h exp 1", swap_pending); end
        s_valid = 1'b1; s_fs = 1'b1; s_data = 8'h20;
        @(negedge clk);
        s_valid = 1'b0; s_fs = 1'b0;
        checks++; if (active_bank !== 1'b1) begin errors++; $display("FAIL nextfs_bank got %h exp 1", active_bank); end
        checks++; if (m_color !== 24'h00ABCD) begin errors++; $display("FAIL nextfs_color got %h exp 00abcd", m_color); end
        s_valid = 1'b1; s_fs = 1'b1; s_data = 8'h21;
        @(negedge clk);
        s_valid = 1'b0; s_fs = 1'b0;
        checks++; if (active_bank !== 1'b1) begin errors++; $display("FAIL idle_fs_bank got %h exp 1", active_bank); end
        @(negedge clk);
    endtask

    task automatic test_reset_pending;
        cfg_load(1'b0, 24'h111111, 256, 1'b1);
        checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL rstp_pending_before got %h exp 1", swap_pending); end
        reset_n = 1'b0;
        #2;
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL rstp_pending got %h exp 0", swap_pending); end
        checks++; if (active_bank !== 1'b0) begin errors++; $display("FAIL rstp_bank got %h exp 0", active_bank); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fs_and_force;
        cfg_load(1'b0, 24'h123456, 256, 1'b1);
        s_valid = 1'b1; s_fs = 1'b1; s_data = 8'h05; ctl_force_swap = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_fs = 1'b0; ctl_force_swap = 1'b0;
        checks++; if (active_bank !== 1'b1) begin errors++; $display("FAIL both_bank got %h exp 1", active_bank); end
        checks++; if (m_color !== 24'h123456) begin errors++; $display("FAIL both_color got %h exp 123456", m_color); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL both_pending got %h exp 0", swap_pending); end
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; cke = 1'b1; m_ready = 1'b1; ctl_force_swap = 1'b0;
        s_cfg_addr = '0; s_cfg_color = '0; s_cfg_last = 1'b0; s_cfg_valid = 1'b0;
        s_user = '0; s_fs = 1'b0; s_data = '0; s_valid = 1'b0;
        test_reset();
        test_load_swap();
        test_pending_stream();
        test_force_swap();
        test_back_to_back();
        test_cke();
        test_last_with_fs();
        test_reset_pending();
        test_fs_and_force();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
